// File: rtl/pim_instr_pkg.sv
// Shared types for the PIM micro-code path: vector/code widths, the
// instruction-type index enum used by encoder and decoder, and FSM states.
package pim_instr_pkg;

    localparam int TYPE_W = 16;
    localparam int CODE_W = 4;

    typedef enum logic [CODE_W-1:0] {
        INIT     = 4'd0,
        CMASK    = 4'd1,
        MASK     = 4'd2,
        TEMP     = 4'd3,
        LUI      = 4'd4,
        PIM_LOAD = 4'd5,
        LS       = 4'd6,
        V        = 4'd7,
        VV       = 4'd8,
        I        = 4'd9
    } instr_type_e;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-set-bit encoder with a popcount==1 flag.
module lsb_prio_enc #(
    parameter int TYPE_W = pim_instr_pkg::TYPE_W,
    parameter int CODE_W = pim_instr_pkg::CODE_W
) (
    input  logic [TYPE_W-1:0] vec,
    output logic [CODE_W-1:0] idx,
    output logic              single
);

    // Scan downward so the lowest set bit is the last one to win.
    always_comb begin
        idx = '0;
        for (int i = TYPE_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

    assign single = (vec != '0) && ((vec & (vec - TYPE_W'(1))) == '0);

endmodule

// File: rtl/instr_type_encoder.sv
// Sequential type-vector encoder: accepts a multi-hot type vector and emits
// one CW_type code per set bit, lowest index first.
module instr_type_encoder #(
    parameter int TYPE_W = pim_instr_pkg::TYPE_W,
    parameter int CODE_W = pim_instr_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TYPE_W-1:0] in_type,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] CW_type,
    output logic              out_last,
    output logic              err_zero
);

    if (CODE_W != $clog2(TYPE_W)) begin : g_bad_width
        $error("CODE_W must equal clog2(TYPE_W)");
    end

    pim_instr_pkg::state_e state, state_n;
    logic [TYPE_W-1:0]     pending, pending_n;
    logic [CODE_W-1:0]     low_idx;
    logic                  single;
    logic                  accept;

    lsb_prio_enc #(
        .TYPE_W(TYPE_W),
        .CODE_W(CODE_W)
    ) u_lsb_prio_enc (
        .vec   (pending),
        .idx   (low_idx),
        .single(single)
    );

    assign accept = in_valid && in_ready && (state == pim_instr_pkg::IDLE);

    always_comb begin
        state_n   = state;
        pending_n = pending;
        case (state)
            pim_instr_pkg::IDLE: begin
                if (accept && (in_type != '0)) begin
                    state_n   = pim_instr_pkg::DRAIN;
                    pending_n = in_type;
                end
            end
            pim_instr_pkg::DRAIN: begin
                if (out_ready) begin
                    pending_n = pending & ~(TYPE_W'(1) << low_idx);
                    if (single) begin
                        state_n = pim_instr_pkg::IDLE;
                    end
                end
            end
            default: state_n = pim_instr_pkg::IDLE;
        endcase
    end

    // in_ready is held low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= pim_instr_pkg::IDLE;
            pending  <= '0;
            in_ready <= 1'b0;
            err_zero <= 1'b0;
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            in_ready <= (state_n == pim_instr_pkg::IDLE);
            err_zero <= accept && (in_type == '0);
        end
    end

    // Outputs depend only on registered state; pending is zero outside DRAIN.
    assign out_valid = (state == pim_instr_pkg::DRAIN);
    assign CW_type   = out_valid ? low_idx : '0;
    assign out_last  = out_valid && single;

endmodule

// File: tb/tb_instr_type_encoder.sv
// Randomized self-checking bench for instr_type_encoder against a queue model
// that lists the set bits of each accepted vector in ascending order.
module tb_instr_type_encoder;

    localparam int TYPE_W = 16;
    localparam int CODE_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [TYPE_W-1:0] in_type = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CODE_W-1:0] CW_type;
    logic              out_last;
    logic              err_zero;

    int n_checks = 0;
    int n_pass   = 0;

    instr_type_encoder #(
        .TYPE_W(TYPE_W),
        .CODE_W(CODE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_type  (in_type),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .CW_type  (CW_type),
        .out_last (out_last),
        .err_zero (err_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_CW_type"}, int'(CW_type), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
    endtask

    // Send one vector, then drain it; the first `hold` drain cycles force out_ready low.
    task automatic run_vec(input logic [TYPE_W-1:0] v, input int stall_pct, input int hold);
        int q[$];
        int budget;
        int cyc;
        for (int k = 0; k < TYPE_W; k++) begin
            if (v[k]) q.push_back(k);
        end

        budget = 0;
        while (!in_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check("ready_before_accept", int'(in_ready), 1);

        cyc = 0;
        in_valid  = 1'b1;
        in_type   = v;
        out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) >= stall_pct);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_type  = TYPE_W'($urandom);

        if (v == '0) begin
            @(negedge clk);
            check("err_zero_pulse", int'(err_zero), 1);
            check("zero_in_ready", int'(in_ready), 1);
            check_idle_outputs("zero");
            @(negedge clk);
            check("err_zero_drop", int'(err_zero), 0);
            check("zero_in_ready2", int'(in_ready), 1);
            check("zero_out_valid2", int'(out_valid), 0);
        end else begin
            budget = 0;
            while (q.size() > 0 && budget < 200) begin
                @(negedge clk);
                check("out_valid", int'(out_valid), 1);
                check("CW_type", int'(CW_type), q[0]);
                check("out_last", int'(out_last), int'(q.size() == 1));
                check("drain_in_ready", int'(in_ready), 0);
                check("drain_err_zero", int'(err_zero), 0);
                if (out_ready) void'(q.pop_front());
                @(posedge clk); #1;
                cyc++;
                out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) >= stall_pct);
                budget++;
            end
            check("drain_timeout", q.size(), 0);
            @(negedge clk);
            check("post_in_ready", int'(in_ready), 1);
            check_idle_outputs("post");
        end
    endtask

    initial begin
        logic [TYPE_W-1:0] v;
        int sel;

        // Reset and release
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_err_zero", int'(err_zero), 0);
        check_idle_outputs("rst");
        @(posedge clk); #1;
        check("rst_ready_rise", int'(in_ready), 1);

        // Directed cases
        run_vec(16'h0080, 0, 0);
        run_vec(16'h0215, 0, 0);
        run_vec(16'h8001, 0, 3);
        run_vec(16'h0000, 0, 0);

        // Reset in the middle of a drain
        while (!in_ready) begin
            @(posedge clk); #1;
        end
        in_valid  = 1'b1;
        in_type   = 16'h0148;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_first_code", int'(CW_type), 3);
        @(posedge clk); #1;
        check("mid_second_code", int'(CW_type), 6);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_err_zero", int'(err_zero), 0);
        check_idle_outputs("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("after_rst_out_valid", int'(out_valid), 0);
        end

        // Randomized vectors with random backpressure
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(3));
            case (sel)
                0: v = TYPE_W'(1) << $urandom_range(TYPE_W - 1);
                1: v = TYPE_W'($urandom) & TYPE_W'($urandom);
                2: v = TYPE_W'($urandom);
                default: v = ($urandom_range(3) == 0) ? '0 : TYPE_W'($urandom) | 16'h8000;
            endcase
            run_vec(v, int'($urandom_range(60)), int'($urandom_range(2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_type_encoder.md
# instr_type_encoder

Sequential encoder for the PIM micro-code path: the inverse of the control-word type decoder. It accepts a 16-bit instruction-type vector (one-hot or multi-hot, bit index = type code) over a valid/ready handshake. It then emits one 4-bit `CW_type` code per set bit, lowest index first, with a strobe that plays the role of `test_jmp_ld`. It sits between the instruction classifier and control-memory word assembly, so the decoder can reproduce each requested type bit in sequence.

## Interface
- `TYPE_W`, default 16: width of the instruction-type vector.
- `CODE_W`, default 4: width of `CW_type`; must equal $clog2(TYPE_W).

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous assertion, active-low.
- `in_valid`  in  1: `in_type` is valid.
- `in_ready`  out  1: block can accept a vector. Registered.
- `in_type`  in  TYPE_W: requested type vector; bit k requests code k.
- `out_valid`  out  1: `CW_type` is valid. This is the load strobe, equivalent to `test_jmp_ld`.
- `out_ready`  in  1: consumer accepts the current code.
- `CW_type`  out  CODE_W: encoded type index.
- `out_last`  out  1: current code is the final one for the accepted vector.
- `err_zero`  out  1: one-cycle pulse when an all-zero vector is accepted.

## Operation
- State machine with two states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - DRAIN: `in_ready`=0, `out_valid`=1.
- Reset:
  - State is IDLE and `pending`=0.
  - Every output reads 0, including `in_ready`.
  - `in_ready` rises on the first clock edge after `rst_n` deasserts.
- Accept: `in_valid`&&`in_ready` while in IDLE.
  - If `in_type`==0: pulse `err_zero` the next cycle, remain in IDLE, produce no output.
  - If `in_type`!=0: load `pending`=`in_type`, go to DRAIN, drop `in_ready`.
- DRAIN outputs:
  - `CW_type` = index of the lowest set bit of `pending`.
  - `out_last` = 1 when `pending` has exactly one bit set.
  - Both are derived only from registered state. There is no combinational path from `in_*` to `out_*`.
- Transfer: `out_valid`&&`out_ready`.
  - Clears the bit at `CW_type` in `pending`.
  - If `out_last` is set: go to IDLE and raise `in_ready` on the next cycle.
- Backpressure: while `out_ready`=0, `CW_type` and `out_last` stay stable and `out_valid` stays high.
- Bits above TYPE_W-1 do not exist. All 16 indices (0–15) are legal, including currently unassigned codes 10–15, and are encoded without checking.
- Round-trip invariant: for every emitted code c, the decoder output (1 << c) equals the bit just cleared from `pending`.
- `in_valid` while `in_ready`=0 is ignored. The upstream block holds `in_type` until the handshake completes.

## Timing
- Latency: vector accepted at edge N; first `out_valid` is high after edge N (cycle N+1).
- Throughput: one code per cycle while `out_ready`=1.
- An n-bit vector occupies n DRAIN cycles plus 1 IDLE cycle before the next accept. A one-hot stream therefore runs at 1 code per 2 cycles.
- `err_zero` is high for exactly the cycle after the zero-vector accept. `in_ready` stays 1 throughout.
- Reset asserted mid-DRAIN: outputs clear immediately (asynchronous) and `pending` is discarded. No partial code is emitted after reset release.
- The last transfer and a new `in_valid` in the same cycle cannot overlap. The new vector is accepted no earlier than the following cycle.

## Structure
- Shared package `pim_instr_pkg` holds:
  - `TYPE_W` and `CODE_W`.
  - The type-index enum: INIT=0, CMASK=1, MASK=2, TEMP=3, LUI=4, PIM_LOAD=5, LS=6, V=7, VV=8, I=9. The decoder uses the same enum.
  - The state enum {IDLE, DRAIN}.
- Sub-module `lsb_prio_enc`: combinational lowest-set-bit index of a TYPE_W vector, plus a `single` flag (popcount==1).
- The top level holds the FSM, the `pending` register, and the output registers.

## Test plan
- Reset release → `in_ready`=0 in the first cycle, 1 at the next edge. All other outputs are 0.
- Accept `in_type`=16'h0080 (V), `out_ready`=1:
  - One cycle later: `out_valid`=1, `CW_type`=7, `out_last`=1.
  - Next cycle: IDLE with `in_ready`=1.
- Accept 16'h0215 (INIT, MASK, LUI, I), `out_ready`=1 → `CW_type` sequence 0, 2, 4, 9 on consecutive cycles, with `out_last` only on 9.
- Accept 16'h8001 with `out_ready` held 0 for 3 cycles → `CW_type`=0 is held stable with `out_valid`=1. After release, 0 then 15 are emitted, `out_last` on 15.
- Accept 16'h0000 → `err_zero` pulses for 1 cycle, `out_valid` stays 0, `in_ready` stays 1.
- Accept 16'h0148, pull `rst_n` low after the first transfer → outputs go to 0 asynchronously. After release there is no further `out_valid` until a new vector is accepted.
